mul32_shiftadd_ctrl: RTL



---
 rtl/mul32_shiftadd_ctrl_if.sv | 28 ++
 rtl/mul32_shiftadd_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mul32_shiftadd_ctrl_if.sv
// Operand/result handshake plus the shared 8-bit add-slice connection for mul32_shiftadd_ctrl.
// Each handshake completes on a rising clk edge where both its valid and its ready are high.
// The slave modport is the sequencer side; the master modport is the requester and adder side.
interface mul32_shiftadd_ctrl_if;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] product;
  logic        busy;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_ci;
  logic [7:0]  add_sum;
  logic        add_co;

  modport slave (
    input  start_valid, op_a, op_b, res_ready, add_sum, add_co,
    output start_ready, res_valid, product, busy, add_a, add_b, add_ci
  );

  modport master (
    output start_valid, op_a, op_b, res_ready, add_sum, add_co,
    input  start_ready, res_valid, product, busy, add_a, add_b, add_ci
  );
endinterface

// File: rtl/mul32_shiftadd_ctrl.sv
// Unsigned 32x32->64 shift-and-add multiplier; each partial sum is four byte-serial passes through one external 8-bit adder.
// Optional macro MUL32_EARLY_EXIT_EN: finish with one barrel shift once the remaining multiplier bits are zero.
module mul32_shiftadd_ctrl #(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic                        clk,
  input  logic                        rst,
  mul32_shiftadd_ctrl_if.slave        bus,
  output logic [1:0]                  fsm_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [63:0] p;
  logic [4:0]  cnt;
  logic [1:0]  bidx;
  logic        carry;
  logic        top;
  logic        start_ready_q;
  logic        res_valid_q;
  logic        busy_q;
  logic [7:0]  add_a_q;
  logic [7:0]  add_b_q;
  logic        add_ci_q;

  logic [63:0] p_shift;
  logic [1:0]  bidx_nx;
  assign p_shift = {top, p[63:1]};
  assign bidx_nx = bidx + 2'd1;

`ifdef MUL32_EARLY_EXIT_EN
  logic [30:0] rem_mask;
  logic        rem_zero;
  logic [64:0] p_jump;
  // rem_mask selects P[31-cnt:1], the multiplier bits not yet examined.
  assign rem_mask = 31'h7FFF_FFFF >> cnt;
  assign rem_zero = ((p[31:1] & rem_mask) == 31'h0);
  assign p_jump   = {top, p} >> (6'd32 - {1'b0, cnt});
`endif

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.busy        = busy_q;
  assign bus.product     = p;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.add_ci      = add_ci_q;
  assign fsm_state       = state;

  // Adder operands are registered one cycle ahead, so they present the byte the ADD cycle consumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mcand         <= '0;
      p             <= '0;
      cnt           <= '0;
      bidx          <= '0;
      carry         <= 1'b0;
      top           <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      add_ci_q      <= 1'b0;
    end else begin
      add_a_q  <= '0;
      add_b_q  <= '0;
      add_ci_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            mcand         <= bus.op_a;
            p             <= {32'h0, bus.op_b};
            cnt           <= '0;
            bidx          <= '0;
            carry         <= 1'b0;
            top           <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            if (bus.op_b[0]) begin
              state   <= ADD;
              add_b_q <= bus.op_a[7:0];
            end else begin
              state <= SHIFT;
            end
          end
        end
        ADD: begin
          p[32 + 8*int'(bidx) +: 8] <= bus.add_sum;
          carry <= bus.add_co;
          if (bidx == 2'd3) begin
            top   <= bus.add_co;
            bidx  <= '0;
            state <= SHIFT;
          end else begin
            bidx     <= bidx_nx;
            add_a_q  <= p[32 + 8*int'(bidx_nx) +: 8];
            add_b_q  <= mcand[8*int'(bidx_nx) +: 8];
            add_ci_q <= bus.add_co;
          end
        end
        SHIFT: begin
          p     <= p_shift;
          top   <= 1'b0;
          carry <= 1'b0;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state       <= DONE;
            res_valid_q <= 1'b1;
`ifdef MUL32_EARLY_EXIT_EN
          end else if (rem_zero) begin
            p           <= p_jump[63:0];
            state       <= DONE;
            res_valid_q <= 1'b1;
`endif
          end else if (p[1]) begin
            state   <= ADD;
            add_a_q <= p_shift[39:32];
            add_b_q <= mcand[7:0];
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
